hs_word_serializer: RTL and testbench

- Clocked source stage that feeds the asynchronous latch pipeline.
- Accepts WIDTH-bit words from synchronous logic over a valid/ready interface.
- Emits each word LSB-first, one bit per handshake, on a 2-phase bundled-data channel (req/ack/dat) into the first hlatch.
- Synchronizes the returning ack, flags protocol errors and stalls, and counts completed words.

---
 rtl/hs_word_serializer.sv | 160 ++++++++++++++++
 tb/tb_hs_word_serializer.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_word_serializer.sv
// Clocked source for the async latch pipeline: takes words on valid/ready and
// sends them LSB-first as 2-phase bundled-data bits (req/ack/dat).
module hs_word_serializer #(
  parameter int   WIDTH       = 8,
  parameter int   SYNC_STAGES = 2,
  parameter logic REQ_INIT    = 1'b0,
  parameter int   TIMEOUT     = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             req_o,
  input  logic             ack_i,
  output logic             dat_o,
  output logic             busy,
  output logic             stall_o,
  output logic             proto_err,
  output logic [15:0]      word_cnt
);

  localparam int   BW             = $clog2(WIDTH + 1);
  localparam int   CW             = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic STALL_AT_ENTRY = (TIMEOUT == 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_req;
  logic                   r_dat;
  logic                   r_in_ready;
  logic                   r_busy;
  logic                   r_stall;
  logic                   r_proto_err;
  logic [15:0]            r_word_cnt;
  logic [WIDTH-1:0]       r_shreg;
  logic [BW-1:0]          r_bits;
  logic [CW-1:0]          r_wait_cnt;

  logic                   w_ack_s;
  logic                   w_pending;
  logic                   w_accept;
  logic                   w_last_bit;
  logic                   w_stall_due;
  logic [WIDTH-1:0]       w_shifted;
  logic [CW-1:0]          w_wait_next;
  logic [15:0]            w_word_cnt_next;

  // Handshake status, shift data, saturating wait count and word counter next value
  always_comb begin
    w_ack_s    = r_sync[SYNC_STAGES-1];
    w_pending  = w_ack_s ^ r_req;
    w_accept   = in_valid & r_in_ready & ~w_pending & ~r_proto_err;
    w_shifted  = r_shreg >> 1;
    w_last_bit = (r_bits == BW'(1));
    if (r_wait_cnt == CW'(TIMEOUT)) begin
      w_wait_next = r_wait_cnt;
    end else begin
      w_wait_next = r_wait_cnt + CW'(1);
    end
    // Registered stall: raise it one cycle early so it is visible in WAIT cycle TIMEOUT
    w_stall_due = (TIMEOUT != 0) && ((32'(r_wait_cnt) + 32'd2) >= 32'(TIMEOUT));
    if ((r_state == S_WAIT) && !w_pending && w_last_bit) begin
      w_word_cnt_next = r_word_cnt + 16'd1;
    end else begin
      w_word_cnt_next = r_word_cnt;
    end
  end

  // Ack synchronizer chain, reset to the idle phase of the channel
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= {SYNC_STAGES{REQ_INIT}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], ack_i};
    end
  end

  // Sender FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_req       <= REQ_INIT;
      r_dat       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_stall     <= 1'b0;
      r_proto_err <= 1'b0;
      r_word_cnt  <= 16'd0;
      r_shreg     <= {WIDTH{1'b0}};
      r_bits      <= {BW{1'b0}};
      r_wait_cnt  <= {CW{1'b0}};
    end else begin
      r_word_cnt <= w_word_cnt_next;
      case (r_state)
        S_IDLE: begin
          if (w_pending) begin
            // An ack edge with nothing outstanding: freeze until reset
            r_proto_err <= 1'b1;
            r_in_ready  <= 1'b0;
          end else if (w_accept) begin
            r_shreg    <= in_data;
            r_bits     <= BW'(WIDTH);
            r_dat      <= in_data[0];
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_SETUP;
          end else begin
            r_in_ready <= ~r_proto_err;
          end
        end
        S_SETUP: begin
          r_req      <= ~r_req;
          r_wait_cnt <= {CW{1'b0}};
          r_stall    <= STALL_AT_ENTRY;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (!w_pending) begin
            r_shreg    <= w_shifted;
            r_bits     <= r_bits - BW'(1);
            r_stall    <= 1'b0;
            r_wait_cnt <= {CW{1'b0}};
            if (w_last_bit) begin
              r_busy     <= 1'b0;
              r_in_ready <= 1'b1;
              r_state    <= S_IDLE;
            end else begin
              r_dat   <= w_shifted[0];
              r_state <= S_SETUP;
            end
          end else begin
            r_wait_cnt <= w_wait_next;
            r_stall    <= r_stall | w_stall_due;
          end
        end
        default: begin
          r_busy     <= 1'b0;
          r_in_ready <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign req_o     = r_req;
  assign dat_o     = r_dat;
  assign busy      = r_busy;
  assign stall_o   = r_stall;
  assign proto_err = r_proto_err;
  assign word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_hs_word_serializer.sv
// Self-checking bench for hs_word_serializer: echoing ack model, req-edge
// monitor and a bit-list reference model of the serialized words.
module tb_hs_word_serializer;

  localparam int W  = 8;
  localparam int SS = 2;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = 8'h00;
  logic         req_o;
  logic         ack_i = 1'b0;
  logic         dat_o;
  logic         busy;
  logic         stall_o;
  logic         proto_err;
  logic [15:0]  word_cnt;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [15:0] exp_cnt = 16'd0;

  bit ack_mode = 1'b0;
  bit ack_hold = 1'b0;
  bit ack_manual = 1'b0;
  int ack_delay = 3;
  int ack_cnt = 0;
  int last_ack_cyc = 0;

  int   mon_toggles = 0;
  int   mon_viol = 0;
  logic mon_prev_req = 1'b0;
  logic mon_prev_dat = 1'b0;
  logic mon_q[$];

  hs_word_serializer #(.WIDTH(W), .SYNC_STAGES(SS), .REQ_INIT(1'b0), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .req_o(req_o), .ack_i(ack_i), .dat_o(dat_o), .busy(busy), .stall_o(stall_o),
    .proto_err(proto_err), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Async pipeline stand-in: echoes req after ack_delay cycles, or drives a manual level
  initial begin
    forever begin
      @(negedge clk);
      if (ack_mode) begin
        if (ack_i !== ack_manual) begin
          ack_i = ack_manual;
          last_ack_cyc = cyc;
        end
        ack_cnt = 0;
      end else if (ack_hold || (req_o === ack_i)) begin
        ack_cnt = 0;
      end else begin
        ack_cnt++;
        if (ack_cnt >= ack_delay) begin
          ack_i = req_o;
          ack_cnt = 0;
          last_ack_cyc = cyc;
        end
      end
    end
  end

  // Records dat_o at every req edge and whether dat_o moved on that same edge
  initial begin
    forever begin
      @(negedge clk);
      if (req_o !== mon_prev_req) begin
        mon_toggles++;
        mon_q.push_back(dat_o);
        if (dat_o !== mon_prev_dat) mon_viol++;
      end
      mon_prev_req = req_o;
      mon_prev_dat = dat_o;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 16'd0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (in_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL ready_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, n);
    end
  endtask

  // Offers a word until it is taken; returns at the negedge after the accepting edge
  task automatic send_word(input logic [W-1:0] w, input bit keep_valid);
    in_valid = 1'b1;
    in_data  = w;
    wait_ready();
    @(negedge clk);
    if (!keep_valid) begin
      in_valid = 1'b0;
      in_data  = W'($urandom);
    end
  endtask

  // Compares monitored req-edge data from index base against the LSB-first bits of the words
  task automatic check_bits(input string name, input int base, input logic [W-1:0] words[$]);
    for (int k = 0; k < words.size(); k++) begin
      for (int i = 0; i < W; i++) begin
        logic exp_b;
        logic got_b;
        exp_b = logic'((words[k] >> i) & 8'd1);
        got_b = (base + k*W + i < mon_q.size()) ? mon_q[base + k*W + i] : 1'bx;
        checks++;
        if (got_b !== exp_b) begin
          errors++;
          $display("FAIL %s_bit: word %0d bit %0d got %b expected %b", name, k, i, got_b, exp_b);
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks += 7;
    if (in_ready !== 1'b0)   begin errors++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
    if (req_o !== 1'b0)      begin errors++; $display("FAIL rst_req: got %b expected 0", req_o); end
    if (dat_o !== 1'b0)      begin errors++; $display("FAIL rst_dat: got %b expected 0", dat_o); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    if (stall_o !== 1'b0)    begin errors++; $display("FAIL rst_stall: got %b expected 0", stall_o); end
    if (proto_err !== 1'b0)  begin errors++; $display("FAIL rst_proto: got %b expected 0", proto_err); end
    if (word_cnt !== 16'd0)  begin errors++; $display("FAIL rst_cnt: got %h expected 0000", word_cnt); end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_2nd: got %b expected 1", in_ready); end
  endtask

  task automatic test_single();
    int base;
    logic start_req;
    logic [W-1:0] words[$];
    ack_delay = 3;
    base = mon_toggles;
    start_req = req_o;
    words = '{8'hA5};
    send_word(8'hA5, 1'b0);
    checks++;
    if (req_o !== start_req) begin errors++; $display("FAIL single_req_early: got %b expected %b", req_o, start_req); end
    @(negedge clk);
    checks++;
    if (req_o !== ~start_req) begin errors++; $display("FAIL single_req_first: got %b expected %b", req_o, ~start_req); end
    wait_idle();
    exp_cnt++;
    checks += 5;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b expected 1", in_ready); end
    if (cyc - last_ack_cyc != SS + 1) begin errors++; $display("FAIL single_ready_lat: got %0d expected %0d", cyc - last_ack_cyc, SS + 1); end
    if (word_cnt !== exp_cnt) begin errors++; $display("FAIL single_cnt: got %h expected %h", word_cnt, exp_cnt); end
    if (req_o !== 1'b0) begin errors++; $display("FAIL single_req_end: got %b expected 0", req_o); end
    if (mon_toggles - base != W) begin errors++; $display("FAIL single_toggles: got %0d expected %0d", mon_toggles - base, W); end
    check_bits("single", base, words);
  endtask

  task automatic test_back_to_back();
    int base;
    int vbase;
    int n;
    logic [W-1:0] words[$];
    base = mon_toggles;
    vbase = mon_viol;
    words = '{8'h01, 8'hFF};
    send_word(8'h01, 1'b1);
    in_data = 8'hFF;
    n = 0;
    while (in_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: busy=%b in_ready=%b expected 0/1", busy, in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept: busy=%b in_ready=%b expected 1/0", busy, in_ready); end
    wait_idle();
    exp_cnt += 16'd2;
    checks += 3;
    if (mon_toggles - base != 2*W) begin errors++; $display("FAIL b2b_toggles: got %0d expected %0d", mon_toggles - base, 2*W); end
    if (word_cnt !== exp_cnt) begin errors++; $display("FAIL b2b_cnt: got %h expected %h", word_cnt, exp_cnt); end
    if (mon_viol != vbase) begin errors++; $display("FAIL b2b_setup: got %0d dat changes at req edges expected 0", mon_viol - vbase); end
    check_bits("b2b", base, words);
  endtask

  task automatic test_stall();
    int base;
    int tog;
    int n;
    logic prev;
    logic [W-1:0] w;
    logic [W-1:0] words[$];
    w = W'($urandom);
    words = '{w};
    base = mon_toggles;
    ack_delay = 3;
    send_word(w, 1'b0);
    prev = req_o;
    tog = 0;
    n = 0;
    while (tog < 4 && n < 300) begin
      @(negedge clk);
      n++;
      if (req_o !== prev) begin
        tog++;
        prev = req_o;
      end
    end
    ack_hold = 1'b1;
    for (int k = 2; k <= TO; k++) begin
      @(negedge clk);
      if (k == TO - 1) begin
        checks++;
        if (stall_o !== 1'b0) begin errors++; $display("FAIL stall_early: got %b expected 0 at wait cycle %0d", stall_o, k); end
      end
    end
    checks += 2;
    if (stall_o !== 1'b1) begin errors++; $display("FAIL stall_set: got %b expected 1 at wait cycle %0d", stall_o, TO); end
    if (req_o !== prev) begin errors++; $display("FAIL stall_req: got %b expected %b", req_o, prev); end
    ack_hold = 1'b0;
    n = 0;
    while (stall_o !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks += 2;
    if (stall_o !== 1'b0) begin errors++; $display("FAIL stall_clear: got %b expected 0", stall_o); end
    if (req_o !== prev) begin errors++; $display("FAIL stall_req_hold: got %b expected %b", req_o, prev); end
    wait_idle();
    exp_cnt++;
    checks += 2;
    if (word_cnt !== exp_cnt) begin errors++; $display("FAIL stall_cnt: got %h expected %h", word_cnt, exp_cnt); end
    if (mon_toggles - base != W) begin errors++; $display("FAIL stall_toggles: got %0d expected %0d", mon_toggles - base, W); end
    check_bits("stall", base, words);
  endtask

  task automatic test_random();
    int base;
    int vbase;
    logic [W-1:0] w;
    logic [W-1:0] words[$];
    base = mon_toggles;
    vbase = mon_viol;
    for (int k = 0; k < 8; k++) begin
      w = W'($urandom);
      words.push_back(w);
      ack_delay = int'($urandom_range(1, 5));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_word(w, 1'b0);
      exp_cnt++;
    end
    wait_idle();
    checks += 3;
    if (word_cnt !== exp_cnt) begin errors++; $display("FAIL rand_cnt: got %h expected %h", word_cnt, exp_cnt); end
    if (mon_toggles - base != 8*W) begin errors++; $display("FAIL rand_toggles: got %0d expected %0d", mon_toggles - base, 8*W); end
    if (mon_viol != vbase) begin errors++; $display("FAIL rand_setup: got %0d dat changes at req edges expected 0", mon_viol - vbase); end
    check_bits("rand", base, words);
    ack_delay = 3;
  endtask

  task automatic test_proto();
    logic start_req;
    start_req = req_o;
    @(posedge clk);
    ack_mode = 1'b1;
    ack_manual = ~start_req;
    @(negedge clk);
    repeat (SS) @(negedge clk);
    checks++;
    if (proto_err !== 1'b0) begin errors++; $display("FAIL proto_early: got %b expected 0", proto_err); end
    @(negedge clk);
    checks += 2;
    if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_set: got %b expected 1", proto_err); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL proto_ready: got %b expected 0", in_ready); end
    in_valid = 1'b1;
    in_data = W'($urandom);
    repeat (6) @(negedge clk);
    checks += 3;
    if (busy !== 1'b0) begin errors++; $display("FAIL proto_busy: got %b expected 0", busy); end
    if (req_o !== start_req) begin errors++; $display("FAIL proto_req: got %b expected %b", req_o, start_req); end
    if (word_cnt !== exp_cnt) begin errors++; $display("FAIL proto_cnt: got %h expected %h", word_cnt, exp_cnt); end
    in_valid = 1'b0;
    @(posedge clk);
    ack_manual = start_req;
    repeat (4) @(negedge clk);
    checks += 2;
    if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_sticky: got %b expected 1", proto_err); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL proto_frozen: got %b expected 0", in_ready); end
    do_reset();
    ack_mode = 1'b0;
    checks += 5;
    if (proto_err !== 1'b0) begin errors++; $display("FAIL proto_rst: got %b expected 0", proto_err); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL proto_rst_ready: got %b expected 0", in_ready); end
    if (word_cnt !== 16'd0) begin errors++; $display("FAIL proto_rst_cnt: got %h expected 0000", word_cnt); end
    if (req_o !== 1'b0 || dat_o !== 1'b0) begin errors++; $display("FAIL proto_rst_chan: req=%b dat=%b expected 0/0", req_o, dat_o); end
    if (busy !== 1'b0 || stall_o !== 1'b0) begin errors++; $display("FAIL proto_rst_busy: busy=%b stall=%b expected 0/0", busy, stall_o); end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL proto_rst_ready2: got %b expected 1", in_ready); end
  endtask

  task automatic test_reset_mid();
    int base;
    int tog;
    int n;
    logic prev;
    logic [15:0] pre_cnt;
    logic [W-1:0] words[$];
    words = '{8'h3C};
    pre_cnt = word_cnt;
    send_word(8'h3C, 1'b0);
    prev = req_o;
    tog = 0;
    n = 0;
    while (tog < 5 && n < 300) begin
      @(negedge clk);
      n++;
      if (req_o !== prev) begin
        tog++;
        prev = req_o;
      end
    end
    ack_mode = 1'b1;
    ack_manual = ~req_o;
    do_reset();
    checks += 4;
    if (req_o !== 1'b0) begin errors++; $display("FAIL mid_req: got %b expected 0", req_o); end
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
    if (word_cnt !== pre_cnt) begin errors++; $display("FAIL mid_cnt: got %h expected %h", word_cnt, pre_cnt); end
    if (proto_err !== 1'b0) begin errors++; $display("FAIL mid_proto: got %b expected 0", proto_err); end
    ack_mode = 1'b0;
    @(negedge clk);
    base = mon_toggles;
    send_word(8'h3C, 1'b0);
    wait_idle();
    exp_cnt = pre_cnt + 16'd1;
    checks += 2;
    if (word_cnt !== exp_cnt) begin errors++; $display("FAIL mid_resend_cnt: got %h expected %h", word_cnt, exp_cnt); end
    if (mon_toggles - base != W) begin errors++; $display("FAIL mid_toggles: got %0d expected %0d", mon_toggles - base, W); end
    check_bits("mid", base, words);
  endtask

  task automatic test_wrap();
    int base;
    logic [W-1:0] w;
    logic [W-1:0] words[$];
    force dut.r_word_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.r_word_cnt;
    @(negedge clk);
    exp_cnt = 16'hFFFF;
    checks++;
    if (word_cnt !== exp_cnt) begin errors++; $display("FAIL wrap_preload: got %h expected %h", word_cnt, exp_cnt); end
    w = W'($urandom);
    words = '{w};
    base = mon_toggles;
    send_word(w, 1'b0);
    wait_idle();
    exp_cnt++;
    checks += 4;
    if (word_cnt !== exp_cnt) begin errors++; $display("FAIL wrap_cnt: got %h expected %h", word_cnt, exp_cnt); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL wrap_ready: got %b expected 1", in_ready); end
    if (proto_err !== 1'b0 || stall_o !== 1'b0) begin errors++; $display("FAIL wrap_flags: proto=%b stall=%b expected 0/0", proto_err, stall_o); end
    if (mon_toggles - base != W) begin errors++; $display("FAIL wrap_toggles: got %0d expected %0d", mon_toggles - base, W); end
    check_bits("wrap", base, words);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_random();
    test_proto();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
